fft_bitrev_stage: RTL and testbench
===================================

Name: fft_bitrev_stage

Overview:
- Synthesizable bit-reversal permutation stage for the FFT datapath, with a block-level ap_ctrl_hs handshake.
- Accepts one frame of N complex samples in natural order and writes each into an internal buffer at its bit-reversed address. It then streams the frame out in natural buffer order, i.e. bit-reversed input order.
- Sits between the sample source and the first butterfly stage. Its ap_start/ap_ready/ap_done/ap_idle are the signals the testbench module-status monitor samples.

Parameters:
- N_LOG2, 10, log2 of frame length N (N = 1024 by default; minimum 2).
- DATA_W, 16, width of each real and imaginary component.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserts immediately, released synchronously to clock by the integrator).
- ap_start  in  1  frame start request.
- ap_ready  out  1  one-cycle pulse: stage can accept the next ap_start after this frame.
- ap_done  out  1  one-cycle pulse: frame fully output.
- ap_idle  out  1  high when no frame is in progress.
- in_data  in  2*DATA_W  {imag, real} input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage accepts input.
- out_data  out  2*DATA_W  {imag, real} permuted sample (registered).
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE; counters=0.
  - ap_idle=1; ap_ready=0; ap_done=0; in_ready=0; out_valid=0; out_data=0.
  - Buffer contents are undefined after reset.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - ap_idle=1, in_ready=0.
  - ap_start=1 at a rising edge moves to LOAD and clears the write count wcnt.
- LOAD:
  - in_ready=1. An input handshake is in_valid & in_ready.
  - Each handshake writes mem[bitrev(wcnt)] <= in_data, then wcnt++.
  - bitrev reverses the N_LOG2 bits of its argument.
  - ap_ready is asserted combinationally in the cycle of the handshake with wcnt=N-1. The next state is DRAIN and rcnt is cleared.
  - in_valid=0 inserts bubbles; no state change.
- DRAIN:
  - in_ready=0. Reads mem[rcnt] sequentially; RAM read latency is 1 cycle.
  - Read issue is gated so that at most 2 words are in flight (read stage plus output register). Use an output skid or prefetch register.
  - Required latency: first out_valid rises exactly 2 cycles after the last input handshake.
  - With out_ready held high there are no bubbles: one word per cycle.
  - out_valid=1 with out_ready=0 holds out_data and out_valid stable, with no loss and no duplication.
  - On the handshake of output index N-1, go to DONE.
- DONE:
  - Lasts one cycle: ap_done=1, ap_idle=0, out_valid=0.
  - ap_start=1 in this cycle moves directly to LOAD; otherwise go to IDLE.
- ap_start is ignored in LOAD and DRAIN. It is not latched; the requester holds it until it sees ap_ready.
- Counter widths are N_LOG2 bits. The terminal test uses count==N-1, not overflow; counters return to 0 for the next frame.
- Reset mid-LOAD or mid-DRAIN aborts the frame immediately:
  - no ap_done and no ap_ready are issued;
  - after release the stage is in IDLE with all outputs at reset values.
- ap_ready and ap_done never assert in the same cycle.
- No output is ever presented from a partially loaded frame.

Test Plan:
- Basic permutation: N_LOG2=3; ap_start, inputs 0..7 with in_valid always 1, out_ready=1 -> outputs 0,4,2,6,1,5,3,7.
  - ap_ready pulses on the 8th input cycle; first out_valid 2 cycles later.
  - ap_done one cycle after the 8th output; then ap_idle=1.
- Default size: N_LOG2=10, inputs k=0..1023 -> output j equals bitrev10(j), e.g. j=1 -> 512, j=3 -> 768, j=1023 -> 1023. Exactly 1024 outputs, no bubbles with out_ready=1.
- Backpressure and bubbles: N_LOG2=4; random in_valid (50%) and random out_ready (30%) -> output sequence identical to the reference bitrev order, and out_data stable while out_valid & !out_ready.
- Back-to-back frames: ap_start held high across two frames, N_LOG2=3, frame B = 8..15 -> DONE goes directly to LOAD.
  - Frame B outputs 8,12,10,14,9,13,11,15.
  - ap_done pulses twice; ap_idle stays 0 between frames.
- Start while busy: pulse ap_start during LOAD and during DRAIN -> no effect, with exactly one ap_ready and one ap_done per frame.
- Reset mid-operation: assert reset after 3 inputs (and separately after 2 outputs) -> all outputs return to reset values immediately, with no ap_done.
  - A following clean frame produces the correct permutation.

Source files
------------

// File: rtl/fft_bitrev_stage.sv
// fft_bitrev_stage: loads one frame of N complex samples into a buffer at
// bit-reversed addresses, then streams the buffer out in natural order.
// Block-level control follows the ap_ctrl_hs start/ready/done/idle handshake.
module fft_bitrev_stage #(
  parameter int unsigned N_LOG2 = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  output logic                ap_idle,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_LOG2-1:0]   wcnt_q, wcnt_d;
  logic [N_LOG2-1:0]   rcnt_q, rcnt_d;
  logic [N_LOG2-1:0]   ocnt_q, ocnt_d;
  logic                rd_done_q, rd_done_d;
  logic                wr_en;
  logic                rd_en;
  logic                out_hs;
  logic [2*DATA_W-1:0] out_data_q;
  logic                out_valid_q;

  logic [2*DATA_W-1:0] mem [N];

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    return {<<{a}};
  endfunction

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_hs    = out_valid_q & out_ready;

  // State and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      ocnt_q    <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      ocnt_q    <= ocnt_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Next-state, counter updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    ocnt_d    = ocnt_q;
    rd_done_d = rd_done_q;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    ap_idle   = 1'b0;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (wcnt_q == LAST) begin
            ap_ready  = 1'b1;
            wcnt_d    = '0;
            rcnt_d    = '0;
            ocnt_d    = '0;
            rd_done_d = 1'b0;
            state_d   = DRAIN;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // A read is only issued when the output register is free or being
        // consumed this cycle, so no word is ever overwritten or repeated.
        if (!rd_done_q && (!out_valid_q || out_ready)) begin
          rd_en = 1'b1;
          if (rcnt_q == LAST) begin
            rd_done_d = 1'b1;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        if (out_hs) begin
          if (ocnt_q == LAST) begin
            ocnt_d  = '0;
            state_d = DONE;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        ap_done   = 1'b1;
        rd_done_d = 1'b0;
        if (ap_start) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame buffer write at the bit-reversed address
  always_ff @(posedge clock) begin
    if (wr_en) mem[bitrev(wcnt_q)] <= in_data;
  end

  // Output register doubles as the buffer read register (1-cycle read latency)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (rd_en) begin
      out_data_q  <= mem[rcnt_q];
      out_valid_q <= 1'b1;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_stage.sv
// Directed bench for fft_bitrev_stage at N_LOG2 = 3, 4 and 10.
module tb_fft_bitrev_stage;

  logic clock;
  logic rst_n;

  logic        a_start, a_valid, a_ordy;
  logic [31:0] a_data, a_out_data;
  logic        a_ap_ready, a_ap_done, a_ap_idle, a_in_ready, a_out_valid;

  logic        b_start, b_valid, b_ordy;
  logic [31:0] b_data, b_out_data;
  logic        b_ap_ready, b_ap_done, b_ap_idle, b_in_ready, b_out_valid;

  logic        c_start, c_valid, c_ordy;
  logic [31:0] c_data, c_out_data;
  logic        c_ap_ready, c_ap_done, c_ap_idle, c_in_ready, c_out_valid;

  int nvec = 0;
  int nerr = 0;
  int rdy3 = 0;
  int done3 = 0;
  int both3 = 0;

  int exp3 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_bitrev_stage #(.N_LOG2(3), .DATA_W(16)) u_n3 (
    .clock(clock), .reset(rst_n), .ap_start(a_start), .ap_ready(a_ap_ready),
    .ap_done(a_ap_done), .ap_idle(a_ap_idle), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_ordy));

  fft_bitrev_stage #(.N_LOG2(4), .DATA_W(16)) u_n4 (
    .clock(clock), .reset(rst_n), .ap_start(b_start), .ap_ready(b_ap_ready),
    .ap_done(b_ap_done), .ap_idle(b_ap_idle), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_ordy));

  fft_bitrev_stage #(.N_LOG2(10), .DATA_W(16)) u_n10 (
    .clock(clock), .reset(rst_n), .ap_start(c_start), .ap_ready(c_ap_ready),
    .ap_done(c_ap_done), .ap_idle(c_ap_idle), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_ordy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters for the N=8 instance, sampled mid-cycle
  always begin
    @(negedge clock);
    #3;
    if (a_ap_ready) rdy3++;
    if (a_ap_done) done3++;
    if (a_ap_ready && a_ap_done) both3++;
  end

  function automatic logic [31:0] mk(input int v);
    return {16'(v ^ 32'h5A5A), 16'(v)};
  endfunction

  function automatic int rev10(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (v[i]) r |= (1 << (9 - i));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full N=8 frame; entered on an IDLE or DONE cycle, returns mid DONE cycle.
  task automatic frame3(input int base, input bit hold, input bit end_start, input bit busy);
    int r0, d0;
    r0 = rdy3;
    d0 = done3;
    a_start = 1'b1;
    a_ordy  = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      a_start = busy ? (k == 3) : hold;
      a_valid = 1'b1;
      a_data  = mk(base + k);
      #1;
      chk("n3_in_ready", a_in_ready, 1);
      chk("n3_idle_load", a_ap_idle, 0);
      chk("n3_ap_ready", a_ap_ready, k == 7);
      chk("n3_no_early_out", a_out_valid, 0);
      @(negedge clock);
    end
    a_valid = 1'b0;
    a_start = hold;
    #1;
    chk("n3_latency_gap", a_out_valid, 0);
    chk("n3_in_ready_drain", a_in_ready, 0);
    @(negedge clock);
    for (int j = 0; j < 8; j++) begin
      a_start = busy ? (j == 2) : hold;
      #1;
      chk("n3_out_valid", a_out_valid, 1);
      chk("n3_out_data", a_out_data, mk(base + exp3[j]));
      chk("n3_no_early_done", a_ap_done, 0);
      chk("n3_idle_drain", a_ap_idle, 0);
      @(negedge clock);
    end
    a_start = end_start;
    #1;
    chk("n3_ap_done", a_ap_done, 1);
    chk("n3_idle_done", a_ap_idle, 0);
    chk("n3_valid_done", a_out_valid, 0);
    #3;
    chk("n3_one_ready", rdy3 - r0, 1);
    chk("n3_one_done", done3 - d0, 1);
  endtask

  initial begin
    int r0, d0, k, nout;
    bit seen, stall;
    logic [31:0] held, s1, s3, s1023;

    rst_n = 1'b0;
    a_start = 0; a_valid = 0; a_ordy = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_ordy = 0; b_data = '0;
    c_start = 0; c_valid = 0; c_ordy = 0; c_data = '0;
    s1 = '0; s3 = '0; s1023 = '0; held = '0;

    // Reset state
    @(negedge clock);
    #1;
    chk("rst_idle", a_ap_idle, 1);
    chk("rst_ready", a_ap_ready, 0);
    chk("rst_done", a_ap_done, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    // Basic permutation
    frame3(0, 0, 0, 0);
    @(negedge clock);
    #1;
    chk("n3_idle_after", a_ap_idle, 1);
    chk("n3_done_cleared", a_ap_done, 0);

    // Back-to-back frames with ap_start held
    @(negedge clock);
    frame3(0, 1, 1, 0);
    frame3(8, 1, 0, 0);
    @(negedge clock);
    #1;
    chk("n3_b2b_idle_after", a_ap_idle, 1);

    // Start pulses while busy
    @(negedge clock);
    frame3(32'h40, 0, 0, 1);
    @(negedge clock);
    #1;
    chk("n3_busy_idle_after", a_ap_idle, 1);

    // Reset mid-LOAD after 3 inputs
    @(negedge clock);
    r0 = rdy3;
    d0 = done3;
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_data  = mk(32'h30 + i);
      @(negedge clock);
    end
    a_valid = 1'b0;
    #1;
    chk("load_abort_pre", a_in_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("load_abort_in_ready", a_in_ready, 0);
    chk("load_abort_idle", a_ap_idle, 1);
    chk("load_abort_ready", a_ap_ready, 0);
    chk("load_abort_done", a_ap_done, 0);
    chk("load_abort_valid", a_out_valid, 0);
    chk("load_abort_data", a_out_data, 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    #1;
    chk("load_abort_idle_post", a_ap_idle, 1);
    chk("load_abort_valid_post", a_out_valid, 0);
    #3;
    chk("load_abort_no_ready", rdy3 - r0, 0);
    chk("load_abort_no_done", done3 - d0, 0);
    frame3(32'h50, 0, 0, 0);
    @(negedge clock);

    // Reset mid-DRAIN after 2 outputs
    r0 = rdy3;
    a_start = 1'b1;
    a_ordy  = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1;
      a_data  = mk(32'h20 + i);
      @(negedge clock);
    end
    a_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("drain_abort_pre", a_out_data, mk(32'h22));
    d0 = done3;
    rst_n = 1'b0;
    #1;
    chk("drain_abort_valid", a_out_valid, 0);
    chk("drain_abort_data", a_out_data, 0);
    chk("drain_abort_idle", a_ap_idle, 1);
    chk("drain_abort_done", a_ap_done, 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    #4;
    chk("drain_abort_no_done", done3 - d0, 0);
    chk("drain_abort_one_ready", rdy3 - r0, 1);
    frame3(32'h60, 0, 0, 0);
    @(negedge clock);

    // N=16 with input bubbles and output backpressure
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    k = 0;
    nout = 0;
    seen = 1'b0;
    stall = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      b_valid = (k < 16) && ($urandom_range(1, 0) == 1);
      b_data  = mk(32'h1000 + k);
      b_ordy  = ($urandom_range(9, 0) < 3);
      #1;
      if (b_ap_done) seen = 1'b1;
      if (stall) begin
        chk("n4_hold_valid", b_out_valid, 1);
        chk("n4_hold_data", b_out_data, held);
      end
      if (b_valid && b_in_ready) k++;
      if (b_out_valid && b_ordy) begin
        if (nout < 16) chk("n4_order", b_out_data, mk(32'h1000 + exp4[nout]));
        nout++;
      end
      stall = b_out_valid && !b_ordy;
      held  = b_out_data;
      @(negedge clock);
    end
    b_valid = 1'b0;
    b_ordy  = 1'b0;
    chk("n4_inputs", k, 16);
    chk("n4_outputs", nout, 16);
    chk("n4_done_seen", seen, 1);

    // N=1024 full frame, no bubbles
    c_start = 1'b1;
    c_ordy  = 1'b1;
    @(negedge clock);
    c_start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      c_valid = 1'b1;
      c_data  = mk(i);
      #1;
      chk("n10_ap_ready", c_ap_ready, i == 1023);
      @(negedge clock);
    end
    c_valid = 1'b0;
    #1;
    chk("n10_latency_gap", c_out_valid, 0);
    @(negedge clock);
    for (int j = 0; j < 1024; j++) begin
      #1;
      chk("n10_out_valid", c_out_valid, 1);
      chk("n10_out_data", c_out_data, mk(rev10(j)));
      if (j == 1) s1 = c_out_data;
      if (j == 3) s3 = c_out_data;
      if (j == 1023) s1023 = c_out_data;
      @(negedge clock);
    end
    #1;
    chk("n10_ap_done", c_ap_done, 1);
    chk("n10_valid_done", c_out_valid, 0);
    chk("n10_j1", s1, mk(512));
    chk("n10_j3", s3, mk(768));
    chk("n10_j1023", s1023, mk(1023));

    chk("n3_ready_done_overlap", both3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
